// File: rtl/torus_inject_sched.sv
// Per-node injection scheduler: per-requester FIFOs feeding one torus_switch injection port, round-robin granted.
// An offer appears 2 cycles after a push and is held until sw_i_ack; req_rdy[k] drops while FIFO k is full.

module torus_inject_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               head_dat,
   output logic [W-1:0]               next_dat,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // next_dat lets the scheduler re-offer from the same FIFO in the cycle its head is popped
   assign head_dat = mem[rd_ptr];
   assign next_dat = mem[rd_ptr + AW'(1)];
endmodule

module torus_inject_sched #(
   parameter int X_W     = 2,
   parameter int Y_W     = 2,
   parameter int D_W     = 32,
   parameter int NREQ    = 4,
   parameter int DEPTH   = 4,
   parameter int MAXWAIT = 15,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_v,
   input  logic [NREQ*X_W-1:0]        req_x,
   input  logic [NREQ*Y_W-1:0]        req_y,
   input  logic [NREQ*D_W-1:0]        req_data,
   output logic [NREQ-1:0]            req_rdy,
   output logic                       sw_i_v,
   output logic [X_W-1:0]             sw_i_x,
   output logic [Y_W-1:0]             sw_i_y,
   output logic [D_W-1:0]             sw_i_data,
   input  logic                       sw_i_ack,
   input  logic                       sw_o_v,
   input  logic                       sw_done,
   output logic [$clog2(NREQ)-1:0]    grant_id,
   output logic [CNT_W-1:0]           inj_cnt,
   output logic [CNT_W-1:0]           ej_cnt,
   output logic                       stall,
   output logic                       idle
);
   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(MAXWAIT + 1);

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [D_W-1:0] data;
   } hdr_t;

   localparam int EW = $bits(hdr_t);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t            state, state_n;
   hdr_t              off_q, off_n;
   logic [GW-1:0]     grant_q, grant_n;
   logic [GW-1:0]     rr_q, rr_n;
   logic [WW-1:0]     wait_q, wait_n;
   logic [CNT_W-1:0]  inj_q, ej_q;
   logic              stall_q, idle_q;

   logic [EW-1:0]     head   [NREQ];
   logic [EW-1:0]     second [NREQ];
   logic [CW-1:0]     cnt    [NREQ];
   logic [CW-1:0]     cnt_nxt[NREQ];
   logic [NREQ-1:0]   push, pop, elig, busy_nxt;
   logic              ack_ok;
   logic              found;
   logic [GW-1:0]     sel, idx;

   // an ack only counts while an offer is actually on the port
   assign ack_ok = (state == OFFER) && sw_i_ack;

   for (genvar k = 0; k < NREQ; k++) begin : g_req
      hdr_t in_dat;
      assign in_dat      = {req_x[k*X_W +: X_W], req_y[k*Y_W +: Y_W], req_data[k*D_W +: D_W]};
      assign req_rdy[k]  = cnt[k] < CW'(DEPTH);
      assign push[k]     = req_v[k] & req_rdy[k];
      assign pop[k]      = ack_ok && (grant_q == GW'(k));
      assign elig[k]     = cnt[k] > (pop[k] ? CW'(1) : CW'(0));
      assign cnt_nxt[k]  = cnt[k] + CW'(push[k]) - CW'(pop[k]);
      assign busy_nxt[k] = (cnt_nxt[k] != CW'(0));

      torus_inject_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (push[k]),
         .push_dat (in_dat),
         .pop      (pop[k]),
         .head_dat (head[k]),
         .next_dat (second[k]),
         .count    (cnt[k])
      );
   end

   always_comb begin
      state_n = state;
      off_n   = off_q;
      grant_n = grant_q;
      rr_n    = rr_q;
      wait_n  = wait_q;
      found   = 1'b0;
      sel     = '0;
      idx     = '0;

      if (ack_ok) begin
         rr_n = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
      end

      for (int i = 0; i < NREQ; i++) begin
         idx = GW'((int'(rr_n) + i) % NREQ);
         if (!found && elig[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end

      case (state)
         IDLE: begin
            wait_n = '0;
            if (found) begin
               state_n = OFFER;
               grant_n = sel;
               off_n   = hdr_t'(head[sel]);
            end
         end
         OFFER: begin
            if (sw_i_ack) begin
               wait_n = '0;
               if (found) begin
                  grant_n = sel;
                  off_n   = pop[sel] ? hdr_t'(second[sel]) : hdr_t'(head[sel]);
               end else begin
                  state_n = IDLE;
               end
            end else if (wait_q != WW'(MAXWAIT)) begin
               wait_n = wait_q + WW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         off_q   <= '0;
         grant_q <= '0;
         rr_q    <= '0;
         wait_q  <= '0;
         inj_q   <= '0;
         ej_q    <= '0;
         stall_q <= 1'b0;
         idle_q  <= sw_done;
      end else begin
         state   <= state_n;
         off_q   <= off_n;
         grant_q <= grant_n;
         rr_q    <= rr_n;
         wait_q  <= wait_n;
         if (ack_ok) begin
            inj_q <= inj_q + CNT_W'(1);
         end
         if (sw_o_v) begin
            ej_q <= ej_q + CNT_W'(1);
         end
         // status flags track the state being entered so they line up with the registered offer
         stall_q <= (state_n == OFFER) && (wait_n == WW'(MAXWAIT));
         idle_q  <= sw_done && (state_n == IDLE) && (busy_nxt == '0);
      end
   end

   assign sw_i_v    = (state == OFFER);
   assign sw_i_x    = off_q.x;
   assign sw_i_y    = off_q.y;
   assign sw_i_data = off_q.data;
   assign grant_id  = grant_q;
   assign inj_cnt   = inj_q;
   assign ej_cnt    = ej_q;
   assign stall     = stall_q;
   assign idle      = idle_q;
endmodule

// File: tb/tb_torus_inject_sched.sv
// Randomized bench for torus_inject_sched: queue-level reference model feeding a scoreboard of expected offers.

module tb_torus_inject_sched;
   localparam int X_W = 2, Y_W = 2, D_W = 32, NREQ = 4, DEPTH = 4, MAXWAIT = 15, CNT_W = 8;
   localparam int GW = $clog2(NREQ);

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NREQ-1:0]         req_v;
   logic [NREQ*X_W-1:0]     req_x;
   logic [NREQ*Y_W-1:0]     req_y;
   logic [NREQ*D_W-1:0]     req_data;
   logic [NREQ-1:0]         req_rdy;
   logic                    sw_i_v;
   logic [X_W-1:0]          sw_i_x;
   logic [Y_W-1:0]          sw_i_y;
   logic [D_W-1:0]          sw_i_data;
   logic                    sw_i_ack;
   logic                    sw_o_v;
   logic                    sw_done;
   logic [GW-1:0]           grant_id;
   logic [CNT_W-1:0]        inj_cnt;
   logic [CNT_W-1:0]        ej_cnt;
   logic                    stall;
   logic                    idle;

   always #5 clk = ~clk;

   torus_inject_sched #(.X_W(X_W), .Y_W(Y_W), .D_W(D_W), .NREQ(NREQ), .DEPTH(DEPTH),
                        .MAXWAIT(MAXWAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req_v(req_v), .req_x(req_x), .req_y(req_y), .req_data(req_data),
      .req_rdy(req_rdy), .sw_i_v(sw_i_v), .sw_i_x(sw_i_x), .sw_i_y(sw_i_y), .sw_i_data(sw_i_data),
      .sw_i_ack(sw_i_ack), .sw_o_v(sw_o_v), .sw_done(sw_done), .grant_id(grant_id),
      .inj_cnt(inj_cnt), .ej_cnt(ej_cnt), .stall(stall), .idle(idle)
   );

   typedef struct packed {
      logic [GW-1:0]  g;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [D_W-1:0] d;
   } pkt_t;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // reference model: queue contents as seen by the arbiter, plus the offer currently on the port
   pkt_t             mq [NREQ][$];
   pkt_t             exp_q[$];
   pkt_t             m_cur;
   bit               m_v;
   int               m_rr;
   int               m_wait;
   logic [CNT_W-1:0] m_inj, m_ej;
   bit               m_stall, m_idle;
   int               sz [NREQ];
   bit               found;
   bit               all_empty;

   // requester-side pending packets (held until accepted)
   logic [NREQ-1:0]  pend_v = '0;
   logic [X_W-1:0]   pend_x [NREQ];
   logic [Y_W-1:0]   pend_y [NREQ];
   logic [D_W-1:0]   pend_d [NREQ];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NREQ; k++) mq[k].delete();
         exp_q.delete();
         m_cur = '0; m_v = 0; m_rr = 0; m_wait = 0; m_inj = '0; m_ej = '0;
         m_stall = 0; m_idle = sw_done;
         chk_en = 1'b1;
      end else begin
         for (int k = 0; k < NREQ; k++) sz[k] = mq[k].size();
         if (m_v && sw_i_ack) begin
            void'(mq[m_cur.g].pop_front());
            m_inj = m_inj + 1'b1;
            m_rr = (int'(m_cur.g) + 1) % NREQ;
         end
         if (!m_v || sw_i_ack) begin
            found = 0;
            m_wait = 0;
            for (int i = 0; i < NREQ; i++) begin
               if (!found && mq[(m_rr + i) % NREQ].size() > 0) begin
                  found = 1;
                  m_cur = mq[(m_rr + i) % NREQ][0];
                  exp_q.push_back(m_cur);
               end
            end
            m_v = found;
         end else if (m_wait < MAXWAIT) begin
            m_wait++;
         end
         if (sw_o_v) m_ej = m_ej + 1'b1;
         for (int k = 0; k < NREQ; k++) begin
            if (req_v[k] && sz[k] < DEPTH)
               mq[k].push_back('{g: GW'(k), x: req_x[k*X_W +: X_W], y: req_y[k*Y_W +: Y_W],
                                 d: req_data[k*D_W +: D_W]});
         end
         m_stall = m_v && (m_wait == MAXWAIT);
         all_empty = 1;
         for (int k = 0; k < NREQ; k++) if (mq[k].size() != 0) all_empty = 0;
         m_idle = sw_done && !m_v && all_empty;
      end
   end

   // monitor: per-cycle state checks plus scoreboard pop on every accepted offer
   always @(negedge clk) begin
      if (chk_en) begin
         logic [NREQ-1:0] m_rdy;
         pkt_t            got;
         for (int k = 0; k < NREQ; k++) m_rdy[k] = (mq[k].size() < DEPTH);
         chk("sw_i_v", 64'(sw_i_v), 64'(m_v));
         chk("grant_id", 64'(grant_id), 64'(m_cur.g));
         chk("sw_i_x", 64'(sw_i_x), 64'(m_cur.x));
         chk("sw_i_y", 64'(sw_i_y), 64'(m_cur.y));
         chk("sw_i_data", 64'(sw_i_data), 64'(m_cur.d));
         chk("inj_cnt", 64'(inj_cnt), 64'(m_inj));
         chk("ej_cnt", 64'(ej_cnt), 64'(m_ej));
         chk("stall", 64'(stall), 64'(m_stall));
         chk("idle", 64'(idle), 64'(m_idle));
         chk("req_rdy", 64'(req_rdy), 64'(m_rdy));
         if (sw_i_v && sw_i_ack && !rst) begin
            got = '{g: grant_id, x: sw_i_x, y: sw_i_y, d: sw_i_data};
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_pkt: accepted %0h with no expected offer at %0t", got, $time);
            end else begin
               chk("sb_pkt", 64'(got), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input int p_req, input int p_ack, input int p_ov,
                      input int p_rst, input bit done_hi);
      for (int c = 0; c < n; c++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!pend_v[k] && $urandom_range(99) < p_req) begin
               pend_v[k] = 1'b1;
               pend_x[k] = X_W'($urandom);
               pend_y[k] = Y_W'($urandom);
               pend_d[k] = $urandom;
            end
            req_x[k*X_W +: X_W]    = pend_x[k];
            req_y[k*Y_W +: Y_W]    = pend_y[k];
            req_data[k*D_W +: D_W] = pend_d[k];
         end
         req_v    = pend_v;
         sw_i_ack = ($urandom_range(99) < p_ack);
         sw_o_v   = ($urandom_range(99) < p_ov);
         rst      = ($urandom_range(999) < p_rst);
         sw_done  = done_hi ? 1'b1 : 1'($urandom_range(1));
         @(negedge clk);
         pend_v = pend_v & ~(req_v & req_rdy);
         sync();
      end
   endtask

   initial begin
      rst = 1'b1; req_v = '0; req_x = '0; req_y = '0; req_data = '0;
      sw_i_ack = 1'b0; sw_o_v = 1'b0; sw_done = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         pend_x[k] = '0; pend_y[k] = '0; pend_d[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single packet from requester 2, always acked
      pend_v[2] = 1'b1; pend_x[2] = 2'd1; pend_y[2] = 2'd0; pend_d[2] = 32'hA5;
      run(8, 0, 100, 0, 0, 1'b1);
      @(negedge clk);
      chk("t1_inj", 64'(inj_cnt), 64'd1);
      chk("t1_grant", 64'(grant_id), 64'd2);
      chk("t1_x", 64'(sw_i_x), 64'd1);
      chk("t1_data", 64'(sw_i_data), 64'hA5);
      chk("t1_idle", 64'(idle), 64'd1);
      sync();

      // fill every FIFO with the port stalled
      run(40, 100, 0, 0, 0, 1'b1);
      @(negedge clk);
      chk("full_rdy", 64'(req_rdy), 64'd0);
      chk("full_stall", 64'(stall), 64'd1);
      sync();

      // reset mid-offer with packets queued
      pend_v = '0; req_v = '0; sw_i_ack = 1'b0; rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_v", 64'(sw_i_v), 64'd0);
      chk("rst_rdy", 64'(req_rdy), 64'hF);
      chk("rst_inj", 64'(inj_cnt), 64'd0);
      sync();
      run(6, 0, 100, 0, 0, 1'b1);
      @(negedge clk);
      chk("rst_no_offer", 64'(sw_i_v), 64'd0);
      sync();

      // back-to-back drain, then mixed random traffic
      run(40, 100, 0, 0, 0, 1'b1);
      run(30, 0, 100, 0, 0, 1'b1);
      run(400, 50, 60, 30, 0, 1'b0);
      run(300, 80, 30, 20, 10, 1'b0);
      run(600, 20, 90, 50, 0, 1'b0);
      run(80, 0, 100, 0, 0, 1'b1);
      @(negedge clk);
      chk("final_idle", 64'(idle), 64'd1);
      chk("final_sb_left", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/torus_inject_sched.md
Name: torus_inject_sched

Overview:
- Per-node injection scheduler in front of one torus_switch.
- Buffers packets from NREQ local requesters in per-requester FIFOs.
- Arbitrates round-robin for the switch's single injection port and holds each offer stable until the switch acks it.
- Counts injected and ejected packets, flags starved offers, and reports node quiescence.

Parameters:
X_W, 2, destination x address width
Y_W, 2, destination y address width
D_W, 32, payload width
NREQ, 4, number of local requesters (>=2)
DEPTH, 4, entries per requester FIFO (power of 2, >=2)
MAXWAIT, 15, consecutive un-acked offer cycles before stall asserts (>=1)
CNT_W, 16, width of packet counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_v  in  NREQ  per-requester push valid
req_x  in  NREQ*X_W  per-requester dest x (requester k at [k*X_W +: X_W])
req_y  in  NREQ*Y_W  per-requester dest y
req_data  in  NREQ*D_W  per-requester payload
req_rdy  out  NREQ  FIFO k not full
sw_i_v  out  1  injection valid to switch
sw_i_x  out  X_W  injection dest x
sw_i_y  out  Y_W  injection dest y
sw_i_data  out  D_W  injection payload
sw_i_ack  in  1  switch accepted the offer this cycle (combinational from sw_i_v/x/y)
sw_o_v  in  1  switch delivered a packet to this node this cycle
sw_done  in  1  switch reports no traffic in flight
grant_id  out  $clog2(NREQ)  requester index of the current offer
inj_cnt  out  CNT_W  packets injected (acked)
ej_cnt  out  CNT_W  packets ejected (sw_o_v cycles)
stall  out  1  current offer waiting >= MAXWAIT cycles
idle  out  1  all FIFOs empty, no offer pending, sw_done=1

Behaviour:
- Reset (sync, dominant over all other events):
  - All FIFOs are flushed.
  - State goes to IDLE.
  - rr pointer resets to 0, so requester 0 has highest priority first.
  - Outputs after the reset edge: sw_i_v=0; sw_i_x/y/data=0; grant_id=0; inj_cnt=0; ej_cnt=0; stall=0; req_rdy=all 1.
  - idle=sw_done.
  - Reset mid-offer drops the pending packet.
- FIFO push:
  - A push occurs on req_v[k]&req_rdy[k].
  - req_rdy[k] = (count_k < DEPTH), decoded from registered count only.
  - A full FIFO refuses a push even in a cycle where it pops.
  - Pushed data is eligible for arbitration the cycle after the push (no bypass).
- Combinational-loop rule: sw_i_v/x/y/data and grant_id are driven only from registers, never combinationally from req_* or sw_i_ack.
- State machine, two states:
  - IDLE: if any FIFO is non-empty, select the first non-empty index scanning rr, rr+1, … mod NREQ. Register its head entry into the sw_i_* registers, set grant_id, go to OFFER. sw_i_v=1 from the next cycle.
  - OFFER: sw_i_v=1; x/y/data/grant_id are held constant while the offer is un-acked.
    - On sw_i_ack=1: pop FIFO grant_id, set rr=grant_id+1 mod NREQ, increment inj_cnt, clear the wait counter.
    - In the same cycle, re-arbitrate using post-pop occupancy: the granted FIFO counts as non-empty only if count>1. If any FIFO is eligible, load the next head and stay in OFFER, giving back-to-back offers with no bubble. Otherwise go to IDLE and sw_i_v=0 next cycle.
- Stall:
  - The wait counter increments each OFFER cycle with sw_i_ack=0 and saturates at MAXWAIT.
  - stall = (wait==MAXWAIT) && state==OFFER, registered.
  - The counter is cleared on ack and in IDLE.
- Counters:
  - inj_cnt +1 per ack; ej_cnt +1 per sw_o_v cycle.
  - Both wrap modulo 2^CNT_W and update independently in the same cycle.
- sw_i_ack while sw_i_v=0 is ignored (no pop, no count).
- idle is registered: (all counts==0) && state==IDLE && sw_done, sampled each cycle. idle=0 while any push is in its first cycle.
- Fairness: a continuously non-empty requester is granted within NREQ consecutive acks.

Test Plan:
1. Reset, then one push from req 2 (x=1,y=0,data=0xA5), sw_i_ack tied 1 → sw_i_v rises 2 cycles after the push; grant_id=2; sw_i_x=1, sw_i_data=0xA5; inj_cnt=1; FSM back in IDLE; idle=1 once sw_done=1.
2. All 4 FIFOs loaded with 2 packets each, ack always 1 → grant sequence 0,1,2,3,0,1,2,3 with sw_i_v continuously high for 8 cycles; inj_cnt=8.
3. Single offer with sw_i_ack=0 for 20 cycles, then 1 → sw_i_x/y/data stable all 20 cycles; stall=1 from the 16th wait cycle until after the ack; inj_cnt unchanged until the ack.
4. Push 5 packets to req 0 with no ack → req_rdy[0]=0 after 4 accepted; the 5th is held by the requester. After one ack, req_rdy[0]=1 next cycle; FIFO order preserved (data 0,1,2,3).
5. sw_o_v pulsed 3 cycles, one coinciding with an ack; inj_cnt preset near 0xFFFF → ej_cnt=3; inj_cnt wraps 0xFFFF→0x0000.
6. rst asserted mid-OFFER with 3 packets queued → next cycle sw_i_v=0, counters=0, req_rdy=4'b1111; after deassert, no packet is offered without new pushes.
